fetch_unit: RTL

Instruction-fetch sequencer sitting directly downstream of the PC register/mux. It reads the current PC, drives the memory address and enable, waits for the memory-ready handshake, and latches the returned word into IR. It then requests the PC increment by driving LD_PC and PC_SEL back into the PC mux. It also detects unaligned PCs and memory timeouts.

---
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Memory-side bus between the fetch sequencer and instruction memory.
// The fetch unit is the master: it drives address/enable and receives ready/data.
interface fetch_unit_if;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic        mem_r;
    logic [15:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_en,
        input  mem_r,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_en,
        output mem_r,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: IDLE -> MEM (wait for ready) -> INC (load IR, bump PC),
// with unaligned-PC and memory-timeout fault reporting.
module fetch_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   PC,
    input  logic          fetch_req,
    input  logic          flush,
    fetch_unit_if.master  mem,
    output logic [15:0]   IR,
    output logic          ir_valid,
    output logic          LD_PC,
    output logic [1:0]    PC_SEL,
    output logic          fetch_fault,
    output logic [1:0]    fault_code,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_INC  = 2'd2
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);
    localparam logic [1:0] CODE_UNALIGNED = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT   = 2'd2;

    state_t      state_r, state_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [15:0] addr_r, addr_s;
    logic [15:0] ir_r, ir_s;
    logic        fault_r, fault_s;
    logic [1:0]  code_r, code_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers: wait counter, MAR, IR and fault reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 5'd0;
            addr_r  <= 16'h0000;
            ir_r    <= 16'h0000;
            fault_r <= 1'b0;
            code_r  <= 2'd0;
        end else begin
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            ir_r    <= ir_s;
            fault_r <= fault_s;
            code_r  <= code_s;
        end
    end

    // Next-state and next-register decode; flush dominates, then ready, then timeout
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        ir_s    = ir_r;
        fault_s = 1'b0;
        code_s  = code_r;
        case (state_r)
            ST_IDLE: begin
                if (fetch_req && !PC[0]) begin
                    addr_s  = PC;
                    cnt_s   = 5'd0;
                    state_s = ST_MEM;
                end else if (fetch_req) begin
                    fault_s = 1'b1;
                    code_s  = CODE_UNALIGNED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (flush) begin
                    state_s = ST_IDLE;
                end else if (mem.mem_r) begin
                    ir_s    = mem.mem_rdata;
                    state_s = ST_INC;
                end else if (cnt_r == CNT_LAST) begin
                    fault_s = 1'b1;
                    code_s  = CODE_TIMEOUT;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 5'd1;
                end
            end
            ST_INC: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign mem.mem_addr = addr_r;
    assign mem.mem_en   = (state_r == ST_MEM);
    assign IR           = ir_r;
    assign ir_valid     = (state_r == ST_INC);
    assign LD_PC        = (state_r == ST_INC);
    assign PC_SEL       = 2'd0;
    assign fetch_fault  = fault_r;
    assign fault_code   = code_r;
    assign busy         = (state_r != ST_IDLE);

endmodule
